vc_arbiter_mux: RTL and testbench

- Downstream consumer of the two virtual-channel FIFOs (VC0, VC1). Pops one word per cycle from the FIFOs, giving VC0 priority, with a bounded-starvation guarantee for VC1.
- Routes each popped word to one of two destination FIFOs (D0, D1) using a destination bit inside the word.
- Stalls popping while either destination reports almost-full.

---
 rtl/vc_arbiter_mux.sv | 110 +++++++++++
 tb/tb_vc_arbiter_mux.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vc_arbiter_mux.sv
// vc_arbiter_mux: pops the two virtual-channel FIFOs one word per cycle,
// with VC0 priority and bounded starvation of VC1. Each popped word is
// steered to destination D0 or D1 by its destination bit. Popping stops
// while either destination is almost full.
module vc_arbiter_mux #(
  parameter int data_width   = 6,
  parameter int dest_bit     = 4,
  parameter int vc1_max_wait = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [data_width-1:0] data_in_VC0,
  input  logic [data_width-1:0] data_in_VC1,
  input  logic                  empty_VC0,
  input  logic                  empty_VC1,
  input  logic                  almost_full_D0,
  input  logic                  almost_full_D1,
  output logic                  pop_VC0,
  output logic                  pop_VC1,
  output logic                  push_D0,
  output logic                  push_D1,
  output logic [data_width-1:0] data_out_D0,
  output logic [data_width-1:0] data_out_D1,
  output logic                  idle_out
);

  localparam logic [2:0] max_wait = 3'(vc1_max_wait);

  logic                  clear;
  logic                  pause;
  logic                  force1;
  logic                  pop_any;
  logic                  valid_reg;
  logic                  src_reg;
  logic                  idle_reg;
  logic [2:0]            wait_cnt_reg;
  logic [2:0]            wait_cnt_next;
  logic [data_width-1:0] word;

  // Both the hard reset and the soft clear are active low.
  assign clear   = ~reset | ~init;
  assign pause   = almost_full_D0 | almost_full_D1;
  assign pop_any = pop_VC0 | pop_VC1;

  // Grant: VC0 wins unless VC1 has waited vc1_max_wait VC0 grants.
  always_comb begin
    force1  = (wait_cnt_reg == max_wait) & ~empty_VC1;
    pop_VC1 = ~clear & ~pause & ~empty_VC1 & (empty_VC0 | force1);
    pop_VC0 = ~clear & ~pause & ~empty_VC0 & ~pop_VC1;
  end

  // Starvation counter: counts VC0 grants made while VC1 is waiting.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (empty_VC1 || pop_VC1) begin
      wait_cnt_next = 3'd0;
    end else if (pop_VC0 && (wait_cnt_reg != max_wait)) begin
      wait_cnt_next = wait_cnt_reg + 3'd1;
    end
  end

  // Pop-capture stage, starvation counter and idle flag.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_reg    <= 1'b0;
      src_reg      <= 1'b0;
      wait_cnt_reg <= 3'd0;
      idle_reg     <= 1'b1;
    end else begin
      valid_reg    <= pop_any;
      src_reg      <= pop_VC1;
      wait_cnt_reg <= wait_cnt_next;
      idle_reg     <= empty_VC0 & empty_VC1 & ~valid_reg & ~pop_any;
    end
  end

  // The FIFO read data is valid one cycle after the pop, so select it here.
  assign word = src_reg ? data_in_VC1 : data_in_VC0;

  // One routing register pair per destination; gi is the dest_bit value it owns.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dest
      logic                  push_reg;
      logic [data_width-1:0] data_reg;

      // Push the captured word here when its destination bit selects gi.
      always_ff @(posedge clk) begin
        if (clear) begin
          push_reg <= 1'b0;
          data_reg <= '0;
        end else if (valid_reg && (word[dest_bit] == 1'(gi))) begin
          push_reg <= 1'b1;
          data_reg <= word;
        end else begin
          push_reg <= 1'b0;
          data_reg <= '0;
        end
      end
    end
  endgenerate

  assign push_D0     = g_dest[0].push_reg;
  assign push_D1     = g_dest[1].push_reg;
  assign data_out_D0 = g_dest[0].data_reg;
  assign data_out_D1 = g_dest[1].data_reg;
  assign idle_out    = idle_reg;

endmodule

// File: tb/tb_vc_arbiter_mux.sv
// tb_vc_arbiter_mux: directed checks of reset, routing, priority/starvation,
// pause, soft clear and drain, against two simple VC FIFO models.
module tb_vc_arbiter_mux;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init = 1'b1;
  logic [5:0] data_in_VC0 = '0;
  logic [5:0] data_in_VC1 = '0;
  logic       empty_VC0;
  logic       empty_VC1;
  logic       almost_full_D0 = 1'b0;
  logic       almost_full_D1 = 1'b0;
  logic       pop_VC0, pop_VC1, push_D0, push_D1, idle_out;
  logic [5:0] data_out_D0, data_out_D1;

  int total = 0;
  int bad = 0;

  // VC FIFO models: registered read data, empty updates on the pop edge.
  logic [5:0] mem0 [64];
  logic [5:0] mem1 [64];
  int rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;
  assign empty_VC0 = (rd0 == wr0);
  assign empty_VC1 = (rd1 == wr1);

  // Push counters, sampled mid-cycle.
  int n_d0 = 0, n_d1 = 0;

  vc_arbiter_mux #(.data_width(6), .dest_bit(4), .vc1_max_wait(4)) dut (
    .clk(clk), .reset(reset), .init(init),
    .data_in_VC0(data_in_VC0), .data_in_VC1(data_in_VC1),
    .empty_VC0(empty_VC0), .empty_VC1(empty_VC1),
    .almost_full_D0(almost_full_D0), .almost_full_D1(almost_full_D1),
    .pop_VC0(pop_VC0), .pop_VC1(pop_VC1),
    .push_D0(push_D0), .push_D1(push_D1),
    .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
    .idle_out(idle_out)
  );

  always #5 clk = ~clk;

  // FIFO read side.
  always @(posedge clk) begin
    if (pop_VC0) begin
      data_in_VC0 <= mem0[rd0];
      rd0 <= rd0 + 1;
    end
    if (pop_VC1) begin
      data_in_VC1 <= mem1[rd1];
      rd1 <= rd1 + 1;
    end
  end

  // Count destination pushes.
  always @(negedge clk) begin
    if (push_D0) n_d0 <= n_d0 + 1;
    if (push_D1) n_d1 <= n_d1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s val=%0h", tag, got);
    end
  endtask

  task automatic load0(input logic [5:0] w);
    mem0[wr0] = w;
    wr0 = wr0 + 1;
  endtask

  task automatic load1(input logic [5:0] w);
    mem1[wr1] = w;
    wr1 = wr1 + 1;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 40 && !idle_out; k++) @(negedge clk);
    chk(tag, idle_out, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] grant_vc1;
    int d0_before, d1_before, sum;

    // ---- Reset with VC0 non-empty ----
    load0(6'h05);
    load0(6'h15);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_pops", {pop_VC1, pop_VC0}, 2'b00);
      chk("rst_push", {push_D1, push_D0}, 2'b00);
      chk("rst_data", {data_out_D1, data_out_D0}, 12'h000);
      chk("rst_idle", idle_out, 1);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rt_pop_a", {pop_VC1, pop_VC0}, 2'b01);
    chk("rt_idle_a", idle_out, 1);
    @(negedge clk);
    chk("rt_pop_b", {pop_VC1, pop_VC0}, 2'b01);
    chk("rt_idle_b", idle_out, 0);
    chk("rt_push_b", {push_D1, push_D0}, 2'b00);
    @(negedge clk);
    chk("rt_pop_c", {pop_VC1, pop_VC0}, 2'b00);
    chk("rt_push_c", {push_D1, push_D0}, 2'b01);
    chk("rt_d0_c", data_out_D0, 6'h05);
    @(negedge clk);
    chk("rt_push_d", {push_D1, push_D0}, 2'b10);
    chk("rt_d1_d", data_out_D1, 6'h15);
    chk("rt_d0_d", data_out_D0, 6'h00);
    chk("rt_idle_d", idle_out, 0);
    @(negedge clk);
    chk("rt_push_e", {push_D1, push_D0}, 2'b00);
    chk("rt_idle_e", idle_out, 1);

    // ---- Priority and starvation: 10 words on each VC ----
    @(posedge clk);
    d0_before = n_d0;
    d1_before = n_d1;
    #1;
    for (int i = 0; i < 10; i++) begin
      load0(6'(i));
      load1(6'(6'h10 | i));
    end
    // bit i set means cycle i grants VC1
    grant_vc1 = 20'b1111_1111_0010_0001_0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("prio_%0d", i), {pop_VC1, pop_VC0}, grant_vc1[i] ? 2'b10 : 2'b01);
    end
    @(negedge clk);
    chk("prio_end", {pop_VC1, pop_VC0}, 2'b00);
    wait_idle("prio_idle");
    @(posedge clk);
    chk("prio_n_d0", n_d0 - d0_before, 10);
    chk("prio_n_d1", n_d1 - d1_before, 10);

    // ---- Pause mid-stream ----
    #1;
    for (int i = 1; i <= 8; i++) load0(6'(i));
    for (int i = 1; i <= 3; i++) load1(6'(6'h30 | i));
    @(negedge clk);
    chk("pz_p0", {pop_VC1, pop_VC0}, 2'b01);
    @(negedge clk);
    chk("pz_p1", {pop_VC1, pop_VC0}, 2'b01);
    @(posedge clk); #1 almost_full_D1 = 1'b1;
    sum = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("pz_hold_%0d", k), {pop_VC1, pop_VC0}, 2'b00);
      sum += int'(push_D0) + int'(push_D1);
    end
    chk("pz_inflight", sum, 2);
    @(posedge clk); #1 almost_full_D1 = 1'b0;
    @(negedge clk);
    chk("pz_q5", {pop_VC1, pop_VC0}, 2'b01);
    @(negedge clk);
    chk("pz_q6", {pop_VC1, pop_VC0}, 2'b01);
    @(negedge clk);
    chk("pz_q7_force", {pop_VC1, pop_VC0}, 2'b10);
    wait_idle("pz_idle");

    // ---- Soft clear with a word in flight ----
    @(posedge clk); #1;
    load0(6'h02);
    load0(6'h03);
    load0(6'h04);
    @(negedge clk);
    chk("sc_s0", {pop_VC1, pop_VC0}, 2'b01);
    @(posedge clk); #1 init = 1'b0;
    @(negedge clk);
    chk("sc_s1_pops", {pop_VC1, pop_VC0}, 2'b00);
    @(posedge clk); #1 init = 1'b1;
    @(negedge clk);
    chk("sc_s2_push", {push_D1, push_D0}, 2'b00);
    chk("sc_s2_data", {data_out_D1, data_out_D0}, 12'h000);
    chk("sc_s2_idle", idle_out, 1);
    chk("sc_s2_pop", {pop_VC1, pop_VC0}, 2'b01);
    @(negedge clk);
    chk("sc_s3_idle", idle_out, 0);
    @(negedge clk);
    chk("sc_s4_push", {push_D1, push_D0}, 2'b01);
    chk("sc_s4_d0", data_out_D0, 6'h03);
    @(negedge clk);
    chk("sc_s5_d0", data_out_D0, 6'h04);
    wait_idle("sc_idle");

    // ---- Drain: VC1-only traffic ----
    @(posedge clk); #1;
    load1(6'h31);
    load1(6'h0a);
    load1(6'h17);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("dr_pop_%0d", k), {pop_VC1, pop_VC0}, 2'b10);
    end
    chk("dr_push_2", {push_D1, push_D0}, 2'b10);
    chk("dr_d1_2", data_out_D1, 6'h31);
    @(negedge clk);
    chk("dr_pop_3", {pop_VC1, pop_VC0}, 2'b00);
    chk("dr_push_3", {push_D1, push_D0}, 2'b01);
    chk("dr_d0_3", data_out_D0, 6'h0a);
    @(negedge clk);
    chk("dr_push_4", {push_D1, push_D0}, 2'b10);
    chk("dr_d1_4", data_out_D1, 6'h17);
    chk("dr_idle_4", idle_out, 0);
    @(negedge clk);
    chk("dr_push_5", {push_D1, push_D0}, 2'b00);
    chk("dr_idle_5", idle_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
